// File: rtl/sobel_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sobel_ctrl_pkg
// Brief    : Shared state encoding and width helpers for the Sobel frame
//            sequencer.
// Revision : 1.0 - initial release
// ============================================================================
package sobel_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        FLUSH  = 2'd2,
        WAIT   = 2'd3
    } in_state_e;

    // Bits needed to hold any value in 0..max_val (never less than one).
    function automatic int unsigned count_width(input int unsigned max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/frame_pos_cnt.sv
`default_nettype none
// ============================================================================
// Module   : frame_pos_cnt
// Brief    : Column/row position counter for the output stream, producing
//            end-of-line and end-of-frame flags.
// Revision : 1.0 - initial release
// ============================================================================
module frame_pos_cnt
    import sobel_ctrl_pkg::*;
#(
    parameter int LINE_W_P = 640,
    parameter int MAX_H_P  = 480
) (
    input  logic                         clk_i,
    input  logic                         rstn_i,
    input  logic                         clr_i,
    input  logic                         inc_i,
    input  logic [$clog2(MAX_H_P+1)-1:0] frame_h_i,
    output logic                         eol_o,
    output logic                         last_o
);

    localparam int unsigned COL_W = count_width(LINE_W_P - 1);
    localparam int unsigned ROW_W = $clog2(MAX_H_P + 1);

    localparam logic [COL_W-1:0] c_col_max = COL_W'(LINE_W_P - 1);
    localparam logic [ROW_W-1:0] c_row_one = ROW_W'(1);

    logic [COL_W-1:0] r_col;
    logic [ROW_W-1:0] r_row;

    always_ff @(posedge clk_i) begin
        if (!rstn_i || clr_i) begin
            r_col <= '0;
            r_row <= '0;
        end else if (inc_i) begin
            if (r_col == c_col_max) begin
                r_col <= '0;
                r_row <= r_row + c_row_one;
            end else begin
                r_col <= r_col + COL_W'(1);
            end
        end
    end

    assign eol_o  = (r_col == c_col_max);
    assign last_o = eol_o && (r_row == frame_h_i - c_row_one);

endmodule
`default_nettype wire

// File: rtl/sobel_frame_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : sobel_frame_ctrl
// Brief    : Per-frame sequencer around the Sobel datapath: forwards pixels,
//            injects flush pixels, drops warm-up results, tags line/frame ends.
// Revision : 1.0 - initial release
// ============================================================================
module sobel_frame_ctrl
    import sobel_ctrl_pkg::*;
#(
    parameter int WIDTH_P     = 8,
    parameter int LINE_W_P    = 640,
    parameter int MAX_H_P     = 480,
    parameter int LAT_PIX_P   = 2564,
    parameter int FLUSH_VAL_P = 0
) (
    input  logic                         clk_i,
    input  logic                         rstn_i,
    input  logic                         start_i,
    input  logic [$clog2(MAX_H_P+1)-1:0] frame_h_i,
    input  logic                         pix_valid_i,
    output logic                         pix_ready_o,
    input  logic [WIDTH_P-1:0]           pix_data_i,
    output logic                         dp_valid_o,
    input  logic                         dp_ready_i,
    output logic [WIDTH_P-1:0]           dp_data_o,
    input  logic                         res_valid_i,
    output logic                         res_ready_o,
    input  logic [WIDTH_P-1:0]           res_data_i,
    output logic                         out_valid_o,
    input  logic                         out_ready_i,
    output logic [WIDTH_P-1:0]           out_data_o,
    output logic                         out_eol_o,
    output logic                         out_last_o,
    output logic                         busy_o,
    output logic                         done_o,
    output logic                         cfg_err_o
);

    localparam int unsigned H_W   = $clog2(MAX_H_P + 1);
    localparam int unsigned CNT_W = count_width(LINE_W_P * MAX_H_P + LAT_PIX_P);

    localparam logic [CNT_W-1:0]   c_line_w    = CNT_W'(LINE_W_P);
    localparam logic [CNT_W-1:0]   c_lat       = CNT_W'(LAT_PIX_P);
    localparam logic [CNT_W-1:0]   c_one       = CNT_W'(1);
    localparam logic [H_W-1:0]     c_max_h     = H_W'(MAX_H_P);
    localparam logic [WIDTH_P-1:0] c_flush_val = WIDTH_P'(FLUSH_VAL_P);

    in_state_e        r_state;
    logic [H_W-1:0]   r_frame_h;
    logic [CNT_W-1:0] r_in_cnt;
    logic [CNT_W-1:0] r_fl_cnt;
    logic [CNT_W-1:0] r_disc_cnt;
    logic             r_busy;
    logic             r_done;
    logic             r_cfg_err;

    logic [CNT_W-1:0] w_tot;
    logic             w_start_ok;
    logic             w_dp_hs;
    logic             w_discard;
    logic             w_fwd;
    logic             w_disc_hs;
    logic             w_out_hs;
    logic             w_frame_end;
    logic             w_pos_eol;
    logic             w_pos_last;

    assign w_tot      = c_line_w * CNT_W'(r_frame_h);
    assign w_start_ok = (frame_h_i != '0) && (frame_h_i <= c_max_h);

    // Input side: zero-latency pass-through while streaming, constant during flush.
    always_comb begin
        dp_valid_o  = 1'b0;
        pix_ready_o = 1'b0;
        dp_data_o   = '0;
        case (r_state)
            STREAM: begin
                dp_valid_o  = pix_valid_i;
                pix_ready_o = dp_ready_i;
                dp_data_o   = pix_data_i;
            end
            FLUSH: begin
                dp_valid_o = 1'b1;
                dp_data_o  = c_flush_val;
            end
            default: ;
        endcase
    end

    assign w_dp_hs = dp_valid_o && dp_ready_i;

    // Output side: the first LAT_PIX_P results are warm-up garbage and are dropped.
    assign w_discard = r_busy && (r_disc_cnt < c_lat);
    assign w_fwd     = r_busy && !w_discard;

    assign res_ready_o = w_discard || (w_fwd && out_ready_i);
    assign out_valid_o = w_fwd && res_valid_i;
    assign out_data_o  = w_fwd ? res_data_i : '0;
    assign out_eol_o   = w_fwd && w_pos_eol;
    assign out_last_o  = w_fwd && w_pos_last;

    assign w_disc_hs   = w_discard && res_valid_i;
    assign w_out_hs    = out_valid_o && out_ready_i;
    assign w_frame_end = w_out_hs && out_last_o;

    frame_pos_cnt #(
        .LINE_W_P (LINE_W_P),
        .MAX_H_P  (MAX_H_P)
    ) u_pos (
        .clk_i     (clk_i),
        .rstn_i    (rstn_i),
        .clr_i     (w_frame_end),
        .inc_i     (w_out_hs),
        .frame_h_i (r_frame_h),
        .eol_o     (w_pos_eol),
        .last_o    (w_pos_last)
    );

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            r_state    <= IDLE;
            r_frame_h  <= '0;
            r_in_cnt   <= '0;
            r_fl_cnt   <= '0;
            r_disc_cnt <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_cfg_err  <= 1'b0;
        end else begin
            r_done    <= 1'b0;
            r_cfg_err <= 1'b0;
            if (w_frame_end) begin
                r_state    <= IDLE;
                r_in_cnt   <= '0;
                r_fl_cnt   <= '0;
                r_disc_cnt <= '0;
                r_busy     <= 1'b0;
                r_done     <= 1'b1;
            end else begin
                if (w_disc_hs) begin
                    r_disc_cnt <= r_disc_cnt + c_one;
                end
                case (r_state)
                    IDLE: begin
                        if (start_i) begin
                            if (w_start_ok) begin
                                r_frame_h <= frame_h_i;
                                r_state   <= STREAM;
                                r_busy    <= 1'b1;
                            end else begin
                                r_cfg_err <= 1'b1;
                            end
                        end
                    end
                    STREAM: begin
                        if (w_dp_hs) begin
                            r_in_cnt <= r_in_cnt + c_one;
                            if (r_in_cnt == w_tot - c_one) begin
                                r_state <= FLUSH;
                            end
                        end
                    end
                    FLUSH: begin
                        if (w_dp_hs) begin
                            r_fl_cnt <= r_fl_cnt + c_one;
                            if (r_fl_cnt == c_lat - c_one) begin
                                r_state <= WAIT;
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign busy_o    = r_busy;
    assign done_o    = r_done;
    assign cfg_err_o = r_cfg_err;

endmodule
`default_nettype wire

// File: tb/tb_sobel_frame_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_sobel_frame_ctrl
// Brief    : Self-checking bench for sobel_frame_ctrl with an identity FIFO
//            standing in for the datapath.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sobel_frame_ctrl;

    localparam int W_PIX  = 8;
    localparam int LINE_W = 4;
    localparam int MAX_H  = 4;
    localparam int LAT    = 5;
    localparam int DEPTH  = 16;

    logic             clk_i = 1'b0;
    logic             rstn_i;
    logic             start_i;
    logic [2:0]       frame_h_i;
    logic             pix_valid_i;
    logic             pix_ready_o;
    logic [W_PIX-1:0] pix_data_i;
    logic             dp_valid_o;
    logic             dp_ready_i;
    logic [W_PIX-1:0] dp_data_o;
    logic             res_valid_i;
    logic             res_ready_o;
    logic [W_PIX-1:0] res_data_i;
    logic             out_valid_o;
    logic             out_ready_i;
    logic [W_PIX-1:0] out_data_o;
    logic             out_eol_o;
    logic             out_last_o;
    logic             busy_o;
    logic             done_o;
    logic             cfg_err_o;

    sobel_frame_ctrl #(
        .WIDTH_P     (W_PIX),
        .LINE_W_P    (LINE_W),
        .MAX_H_P     (MAX_H),
        .LAT_PIX_P   (LAT),
        .FLUSH_VAL_P (0)
    ) dut (
        .clk_i       (clk_i),
        .rstn_i      (rstn_i),
        .start_i     (start_i),
        .frame_h_i   (frame_h_i),
        .pix_valid_i (pix_valid_i),
        .pix_ready_o (pix_ready_o),
        .pix_data_i  (pix_data_i),
        .dp_valid_o  (dp_valid_o),
        .dp_ready_i  (dp_ready_i),
        .dp_data_o   (dp_data_o),
        .res_valid_i (res_valid_i),
        .res_ready_o (res_ready_o),
        .res_data_i  (res_data_i),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .out_data_o  (out_data_o),
        .out_eol_o   (out_eol_o),
        .out_last_o  (out_last_o),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .cfg_err_o   (cfg_err_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        int   h;
        int   gap;
        int   stall;
        logic exp_err;
        logic exp_busy;
    } vec_t;

    vec_t vecs[8];

    int n_checks = 0;
    int n_fail   = 0;
    int dp_stall = 0;

    logic [W_PIX-1:0] fifo[$];
    logic [W_PIX-1:0] dp_log[$];
    logic [9:0]       out_log[$];   // {last, eol, data}

    logic hs_pix, hs_dp, hs_res, hs_out;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // One clock: present the stub datapath, observe handshakes before the edge,
    // update the stub after them, return at the following falling edge.
    task automatic step();
        dp_ready_i  = (fifo.size() < DEPTH) && ($urandom_range(99) >= dp_stall);
        res_valid_i = (fifo.size() > 0);
        res_data_i  = (fifo.size() > 0) ? fifo[0] : '0;
        #1;
        hs_pix = pix_valid_i && pix_ready_o;
        hs_dp  = dp_valid_o && dp_ready_i;
        hs_res = res_valid_i && res_ready_o;
        hs_out = out_valid_o && out_ready_i;
        if (hs_res) void'(fifo.pop_front());
        if (hs_dp) begin
            fifo.push_back(dp_data_o);
            dp_log.push_back(dp_data_o);
        end
        if (hs_out) out_log.push_back({out_last_o, out_eol_o, out_data_o});
        @(negedge clk_i);
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_busy"},      busy_o,      0);
        check({tag, "_done"},      done_o,      0);
        check({tag, "_cfg_err"},   cfg_err_o,   0);
        check({tag, "_dp_valid"},  dp_valid_o,  0);
        check({tag, "_pix_ready"}, pix_ready_o, 0);
        check({tag, "_res_ready"}, res_ready_o, 0);
        check({tag, "_out_valid"}, out_valid_o, 0);
        check({tag, "_eol_last"},  {out_eol_o, out_last_o}, 0);
        check({tag, "_data"},      {dp_data_o, out_data_o}, 0);
    endtask

    task automatic do_start(input int h);
        dp_log.delete();
        out_log.delete();
        pix_valid_i = 1'b0;
        out_ready_i = 1'b1;
        start_i     = 1'b1;
        frame_h_i   = 3'(h);
        step();
        start_i     = 1'b0;
    endtask

    // Runs a frame already accepted by do_start; base 0 means random pixels.
    task automatic run_frame(input int h, input int gap, input int stall,
                             input int base, input bit inject_start);
        int               tot;
        int               pi;
        int               done_n;
        int               err_n;
        bit               injected;
        bit               last_hs;
        logic [W_PIX-1:0] pix[$];
        logic [W_PIX-1:0] exp_dp[$];
        tot = LINE_W * h;
        pi = 0; done_n = 0; err_n = 0; injected = 0;
        for (int i = 0; i < tot; i++)
            pix.push_back((base == 0) ? W_PIX'($urandom_range(1, 255)) : W_PIX'(base + i));
        exp_dp = pix;
        for (int i = 0; i < LAT; i++) exp_dp.push_back('0);

        for (int cyc = 0; cyc < 2000; cyc++) begin
            pix_valid_i = (pi < tot) && ($urandom_range(99) >= gap);
            if (pi < tot) pix_data_i = pix[pi];
            else          pix_data_i = W_PIX'($urandom);
            out_ready_i = ($urandom_range(99) >= stall);
            if (inject_start && !injected && dp_log.size() >= tot && dp_log.size() < tot + LAT) begin
                start_i   = 1'b1;
                frame_h_i = 3'd1;
                injected  = 1;
            end
            step();
            start_i = 1'b0;
            if (hs_pix) pi++;
            last_hs = hs_out && out_log[out_log.size()-1][9];
            if (cfg_err_o) err_n++;
            if (last_hs) check("done_after_last", done_o, 1);
            if (done_o) begin
                done_n++;
                break;
            end
        end
        pix_valid_i = 1'b0;

        check("frame_done", done_n, 1);
        check("busy_at_done", busy_o, 0);
        check("no_cfg_err_in_frame", err_n, 0);
        check("pix_consumed", pi, tot);
        check("dp_count", dp_log.size(), tot + LAT);
        for (int i = 0; i < dp_log.size() && i < exp_dp.size(); i++)
            check($sformatf("dp_data[%0d]", i), dp_log[i], exp_dp[i]);
        check("out_count", out_log.size(), tot);
        for (int i = 0; i < out_log.size() && i < tot; i++) begin
            check($sformatf("out_data[%0d]", i), out_log[i][7:0], exp_dp[LAT + i]);
            check($sformatf("out_eol[%0d]", i),  out_log[i][8], (i % LINE_W) == LINE_W - 1);
            check($sformatf("out_last[%0d]", i), out_log[i][9], i == tot - 1);
        end
        out_ready_i = 1'b1;
        step();
        check("done_pulse_ends", done_o, 0);
        check("idle_busy", busy_o, 0);
        check("idle_res_ready", res_ready_o, 0);
        check("stub_drained", fifo.size(), 0);
    endtask

    initial begin
        int t1_exp[8];
        t1_exp = '{6, 7, 8, 0, 0, 0, 0, 0};

        vecs[0] = '{h: 0, gap: 0,  stall: 0,  exp_err: 1'b1, exp_busy: 1'b0};
        vecs[1] = '{h: 5, gap: 0,  stall: 0,  exp_err: 1'b1, exp_busy: 1'b0};
        vecs[2] = '{h: 7, gap: 0,  stall: 0,  exp_err: 1'b1, exp_busy: 1'b0};
        vecs[3] = '{h: 2, gap: 30, stall: 30, exp_err: 1'b0, exp_busy: 1'b1};
        vecs[4] = '{h: 4, gap: 20, stall: 40, exp_err: 1'b0, exp_busy: 1'b1};
        vecs[5] = '{h: 3, gap: 50, stall: 10, exp_err: 1'b0, exp_busy: 1'b1};
        vecs[6] = '{h: 1, gap: 0,  stall: 60, exp_err: 1'b0, exp_busy: 1'b1};
        vecs[7] = '{h: 2, gap: 40, stall: 50, exp_err: 1'b0, exp_busy: 1'b1};

        rstn_i = 1'b0; start_i = 1'b1; frame_h_i = 3'd2;
        pix_valid_i = 1'b1; pix_data_i = 8'hA5; out_ready_i = 1'b1;
        dp_ready_i = 1'b1; res_valid_i = 1'b0; res_data_i = '0;
        @(negedge clk_i);
        step();
        step();
        check_quiet("reset");
        rstn_i = 1'b1; start_i = 1'b0;

        // Basic frame, no gaps or stalls.
        dp_stall = 0;
        do_start(2);
        check("t1_busy", busy_o, 1);
        run_frame(2, 0, 0, 1, 0);
        for (int i = 0; i < 8; i++)
            check($sformatf("t1_out[%0d]", i), out_log[i][7:0], t1_exp[i]);

        // Table: rejected heights and randomized frames.
        foreach (vecs[k]) begin
            dp_stall = vecs[k].gap / 2;
            do_start(vecs[k].h);
            check($sformatf("vec%0d_cfg_err", k), cfg_err_o, vecs[k].exp_err);
            check($sformatf("vec%0d_busy", k),    busy_o,    vecs[k].exp_busy);
            if (vecs[k].exp_err) begin
                step();
                check($sformatf("vec%0d_err_pulse", k), cfg_err_o, 0);
                check($sformatf("vec%0d_still_idle", k), busy_o, 0);
                check($sformatf("vec%0d_no_hs", k), dp_log.size() + out_log.size(), 0);
            end else begin
                run_frame(vecs[k].h, vecs[k].gap, vecs[k].stall, 0, 0);
            end
        end

        // Start during flush is ignored; next frame runs on its own.
        dp_stall = 10;
        do_start(2);
        run_frame(2, 20, 20, 1, 1);
        do_start(1);
        check("t4_second_busy", busy_o, 1);
        run_frame(1, 0, 0, 9, 0);
        for (int i = 0; i < 4; i++)
            check($sformatf("t4_out[%0d]", i), out_log[i][7:0], 0);

        // Reset mid-stream after three pixels.
        dp_stall = 0;
        do_start(2);
        for (int n = 0, cyc = 0; n < 3 && cyc < 20; cyc++) begin
            pix_valid_i = 1'b1;
            pix_data_i  = W_PIX'(n + 1);
            step();
            if (hs_pix) n++;
        end
        check("t5_pix_before_reset", dp_log.size(), 3);
        rstn_i = 1'b0;
        pix_valid_i = 1'b0;
        step();
        rstn_i = 1'b1;
        pix_valid_i = 1'b1;
        out_ready_i = 1'b1;
        #1;
        check_quiet("t5_after_reset");
        @(negedge clk_i);
        pix_valid_i = 1'b0;
        fifo.delete();
        do_start(1);
        check("t5_restart_busy", busy_o, 1);
        run_frame(1, 10, 10, 20, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
